parking_gate_ctrl: RTL and testbench

Transaction controller that drives the write side of the parking spot register. It serves car-arrival and car-departure requests and picks the lowest-index empty spot for each arrival. It issues single-cycle En/make_entry/sel writes, times the gate barrier, and reports occupancy, lot-full rejects and register consistency errors. It sits between the gate sensors/ticket logic and the 4-spot register, and consumes that register's F/E outputs.

---
 rtl/parking_gate_ctrl.sv | 132 +++++++++++++
 tb/tb_parking_gate_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: serves arrive/depart requests against a 4-spot register and times the gate barrier
// Ports: CLK/RST (async active-low) | arrive, depart, depart_spot: gate requests, held until ack
//        F/E: full/empty vectors from the spot register | En/make_entry/sel: single-cycle register write
//        spot: last served spot | ack/reject: request completion | gate_open: barrier drive
//        busy: FSM not idle | occupied: count of full spots | err: F and E disagree
module parking_gate_ctrl #(
  parameter int GATE_CYCLES = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       arrive,
  input  logic       depart,
  input  logic [1:0] depart_spot,
  input  logic [3:0] F,
  input  logic [3:0] E,
  output logic       En,
  output logic       make_entry,
  output logic [1:0] sel,
  output logic [1:0] spot,
  output logic       ack,
  output logic       reject,
  output logic       gate_open,
  output logic       busy,
  output logic [2:0] occupied,
  output logic       err
);
  typedef enum logic [2:0] {IDLE, WRITE, GATE, REJECT, WAIT_DROP} state_t;
  state_t state_q, state_d;
  logic [1:0] target_q, target_d, free_idx, sel_q, sel_d, spot_q, spot_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] occupied_q, occupied_d;
  logic mode_q, mode_d, src_q, src_d;
  logic en_q, en_d, make_entry_q, make_entry_d, ack_q, ack_d, reject_q, reject_d;
  logic gate_open_q, gate_open_d, busy_q, busy_d, err_q, err_d;
  always_comb begin
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) free_idx = E[i] ? 2'(i) : free_idx;
    occupied_d = 3'd0;
    for (int i = 0; i < 4; i++) occupied_d = occupied_d + 3'(!E[i]);
  end
  // src_q remembers which request line is being served so WAIT_DROP only watches that one
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    mode_d   = mode_q;
    src_d    = src_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (depart) begin
          src_d    = 1'b1;
          target_d = depart_spot;
          mode_d   = 1'b0;
          state_d  = E[depart_spot] ? REJECT : WRITE;
        end else if (arrive) begin
          src_d    = 1'b0;
          target_d = free_idx;
          mode_d   = 1'b1;
          state_d  = (|E) ? WRITE : REJECT;
        end
      end
      WRITE: begin
        state_d = GATE;
        cnt_d   = 8'(GATE_CYCLES - 1);
      end
      GATE: begin
        state_d = (cnt_q == 8'd0) ? WAIT_DROP : GATE;
        cnt_d   = (cnt_q == 8'd0) ? cnt_q : cnt_q - 8'd1;
      end
      REJECT:    state_d = WAIT_DROP;
      WAIT_DROP: state_d = (src_q ? depart : arrive) ? WAIT_DROP : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  // outputs are decoded from the next state so every output is a plain register
  always_comb begin
    en_d         = state_d == WRITE;
    make_entry_d = en_d ? mode_d : make_entry_q;
    sel_d        = en_d ? target_d : sel_q;
    spot_d       = (state_q == WRITE) ? target_q : spot_q;
    gate_open_d  = state_d == GATE;
    ack_d        = (state_d == REJECT) || (state_d == GATE && cnt_d == 8'd0);
    reject_d     = state_d == REJECT;
    busy_d       = state_d != IDLE;
    err_d        = F != ~E;
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      target_q     <= 2'd0;
      mode_q       <= 1'b0;
      src_q        <= 1'b0;
      cnt_q        <= 8'd0;
      en_q         <= 1'b0;
      make_entry_q <= 1'b0;
      sel_q        <= 2'd0;
      spot_q       <= 2'd0;
      ack_q        <= 1'b0;
      reject_q     <= 1'b0;
      gate_open_q  <= 1'b0;
      busy_q       <= 1'b0;
      occupied_q   <= 3'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      mode_q       <= mode_d;
      src_q        <= src_d;
      cnt_q        <= cnt_d;
      en_q         <= en_d;
      make_entry_q <= make_entry_d;
      sel_q        <= sel_d;
      spot_q       <= spot_d;
      ack_q        <= ack_d;
      reject_q     <= reject_d;
      gate_open_q  <= gate_open_d;
      busy_q       <= busy_d;
      occupied_q   <= occupied_d;
      err_q        <= err_d;
    end
  end
  assign En         = en_q;
  assign make_entry = make_entry_q;
  assign sel        = sel_q;
  assign spot       = spot_q;
  assign ack        = ack_q;
  assign reject     = reject_q;
  assign gate_open  = gate_open_q;
  assign busy       = busy_q;
  assign occupied   = occupied_q;
  assign err        = err_q;
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: randomized and directed check of parking_gate_ctrl against a spot-level model
module tb_parking_gate_ctrl;
  localparam int G = 8;
  logic CLK = 0, RST = 0, arrive = 0, depart = 0;
  logic [1:0] depart_spot = 0;
  logic [3:0] F, E, e_reg, load_val = 4'hf, f_val = 0, occ_m = 0;
  logic load_en = 1, f_ovr = 0;
  logic En, make_entry, ack, reject, gate_open, busy, err;
  logic [1:0] sel, spot, spot_m = 0;
  logic [2:0] occupied;
  int checks = 0, failures = 0;
  always #5 CLK = ~CLK;
  assign E = e_reg;
  assign F = f_ovr ? f_val : ~e_reg;
  always @(posedge CLK) begin
    if (load_en) e_reg <= load_val;
    else if (En) e_reg[sel] <= !make_entry;
  end
  parking_gate_ctrl #(.GATE_CYCLES(G)) dut (
    .CLK(CLK), .RST(RST), .arrive(arrive), .depart(depart), .depart_spot(depart_spot),
    .F(F), .E(E), .En(En), .make_entry(make_entry), .sel(sel), .spot(spot), .ack(ack),
    .reject(reject), .gate_open(gate_open), .busy(busy), .occupied(occupied), .err(err)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask
  task automatic set_e(input logic [3:0] v);
    load_val = v;
    load_en = 1;
    @(negedge CLK);
    load_en = 0;
    occ_m = ~v;
    @(negedge CLK);
  endtask
  // called at a negedge in IDLE; returns at the negedge of the following IDLE cycle
  task automatic serve(input bit dep, input int ds, input int h);
    int tgt, a, idle_k;
    bit rej;
    logic [1:0] exp_spot;
    if (dep) begin
      rej = !occ_m[ds];
      tgt = ds;
    end else begin
      rej = 1;
      tgt = 0;
      for (int i = 3; i >= 0; i--) if (!occ_m[i]) begin rej = 0; tgt = i; end
    end
    a = rej ? 1 : G + 1;
    idle_k = a + (h == 0 ? 2 : h + 1);
    exp_spot = rej ? spot_m : 2'(tgt);
    if (dep) begin depart = 1; depart_spot = 2'(ds); end else arrive = 1;
    for (int k = 1; k <= idle_k; k++) begin
      @(negedge CLK);
      if (k <= a) begin
        chk("en", 8'(En), 8'(!rej && k == 1));
        chk("gate_open", 8'(gate_open), 8'(!rej && k >= 2));
        chk("ack", 8'(ack), 8'(k == a));
        chk("reject", 8'(reject), 8'(rej && k == a));
        chk("busy", 8'(busy), 8'd1);
        if (k == 1 && !rej) begin
          chk("sel", 8'(sel), 8'(tgt));
          chk("make_entry", 8'(make_entry), 8'(!dep));
        end
        if (k == a) chk("spot", 8'(spot), 8'(exp_spot));
      end else if (k < idle_k) begin
        chk("wait_busy", 8'(busy), 8'd1);
        chk("wait_ack", 8'(ack), 8'd0);
        chk("wait_en", 8'(En), 8'd0);
      end else begin
        chk("idle_busy", 8'(busy), 8'd0);
        chk("occupied", 8'(occupied), 8'($countones(occ_m)));
      end
      if (k == a && !rej) begin
        occ_m[tgt] = !dep;
        spot_m = 2'(tgt);
      end
      if (k == a + h) begin
        if (dep) depart = 0; else arrive = 0;
      end
    end
  endtask
  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_en", 8'(En), 8'd0);
    chk("rst_ack", 8'(ack), 8'd0);
    chk("rst_gate", 8'(gate_open), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_occ", 8'(occupied), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    chk("rst_spot", 8'(spot), 8'd0);
    chk("rst_sel", 8'(sel), 8'd0);
    load_en = 0;
    occ_m = 0;
    RST = 1;
    @(negedge CLK);
    @(negedge CLK);
    chk("occ_empty", 8'(occupied), 8'd0);
    serve(0, 0, 0);
    set_e(4'b1010);
    serve(0, 0, 0);
    serve(0, 0, 0);
    set_e(4'b0000);
    serve(0, 0, 0);
    arrive = 1;
    serve(1, 2, 0);
    serve(0, 0, 0);
    set_e(4'b1111);
    serve(1, 1, 5);
    arrive = 1;
    for (int k = 1; k <= 5; k++) @(negedge CLK);
    chk("gate_before_rst", 8'(gate_open), 8'd1);
    #1 RST = 0;
    #1;
    chk("async_gate", 8'(gate_open), 8'd0);
    chk("async_busy", 8'(busy), 8'd0);
    chk("async_ack", 8'(ack), 8'd0);
    chk("async_en", 8'(En), 8'd0);
    arrive = 0;
    spot_m = 0;
    @(negedge CLK);
    RST = 1;
    set_e(4'b1111);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("post_rst_en", 8'(En), 8'd0);
      chk("post_rst_busy", 8'(busy), 8'd0);
    end
    set_e(4'b0001);
    chk("err_clear", 8'(err), 8'd0);
    f_ovr = 1;
    f_val = 4'b0001;
    @(negedge CLK);
    chk("err_set", 8'(err), 8'd1);
    chk("occ_three", 8'(occupied), 8'd3);
    f_ovr = 0;
    @(negedge CLK);
    chk("err_drop", 8'(err), 8'd0);
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) set_e(4'($urandom_range(0, 15)));
      serve(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
